tile_map_scanner: RTL

Upstream sequencer for `tile_drawer`. On `start` it walks a background tile map in row-major order, one entry per tile. For each entry it reads the tile index from map RAM and converts it to a tile ROM base address and a screen x/y. It then pulses `draw` and waits for the drawer's `done` before moving to the next tile. It owns the drawer's `tile_address_volitile`, `x_in_volitile`, `y_in_volitile` and `draw` inputs and consumes its `done`.

---
 rtl/tile_pkg.sv | 38 +++
 rtl/tile_map_scanner.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/tile_pkg.sv
// tile_pkg: shared constants, FSM state encoding and draw-request payload
// for the tile map scanner and tile drawer.
package tile_pkg;

  localparam int unsigned TILE_W      = 8;
  localparam int unsigned TILE_PIXELS = 64;
  localparam int unsigned TILE_SHIFT  = $clog2(TILE_PIXELS);
  localparam int unsigned COORD_SHIFT = $clog2(TILE_W);

  localparam int unsigned SCREEN_W    = 160;
  localparam int unsigned SCREEN_H    = 120;
  localparam int unsigned SCREEN_COLS = SCREEN_W / TILE_W;
  localparam int unsigned SCREEN_ROWS = SCREEN_H / TILE_W;

  localparam int unsigned MAP_ADDR_W  = 10;
  localparam int unsigned TILE_ADDR_W = 16;
  localparam int unsigned COORD_W     = 8;
  localparam int unsigned INDEX_W     = 8;
  localparam int unsigned CNT_W       = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT      = 3'd2,
    ST_LATCH     = 3'd3,
    ST_ISSUE     = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_ADVANCE   = 3'd6,
    ST_FINISH    = 3'd7
  } scan_state_e;

  typedef struct packed {
    logic [TILE_ADDR_W-1:0] tile_address;
    logic [COORD_W-1:0]     x;
    logic [COORD_W-1:0]     y;
  } draw_req_t;

endpackage

// File: rtl/tile_map_scanner.sv
// tile_map_scanner: walks a background tile map row-major, converts each
// tile index into a ROM base address and screen x/y, and hands one tile at a
// time to the tile drawer (draw request, wait for done).
// Ports:
//   clk, reset        - clock, async active-high reset
//   start             - level, sampled in IDLE, begins one map pass
//   map_address/data  - synchronous map RAM read port (1-cycle latency)
//   tile_address,
//   x_out, y_out      - drawer payload, held from ISSUE through WAIT_DONE
//   draw              - one-cycle request to the drawer
//   drawer_done       - drawer completion pulse
//   busy              - high whenever not IDLE
//   frame_done        - one-cycle pulse after the last tile
module tile_map_scanner
  import tile_pkg::*;
#(
  parameter int unsigned         MAP_COLS   = SCREEN_COLS,
  parameter int unsigned         MAP_ROWS   = SCREEN_ROWS,
  parameter logic [15:0]         TILE_BASE  = 16'h0000,
  parameter bit                  SKIP_EN    = 1'b1,
  parameter logic [INDEX_W-1:0]  SKIP_INDEX = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [MAP_ADDR_W-1:0]  map_address,
  input  logic [INDEX_W-1:0]     map_data,
  output logic [TILE_ADDR_W-1:0] tile_address,
  output logic [COORD_W-1:0]     x_out,
  output logic [COORD_W-1:0]     y_out,
  output logic                   draw,
  input  logic                   drawer_done,
  output logic                   busy,
  output logic                   frame_done
);

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(MAP_COLS - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MAP_ROWS - 1);

  scan_state_e           state_q, state_d;
  logic [CNT_W-1:0]      col_q, col_d;
  logic [CNT_W-1:0]      row_q, row_d;
  logic [MAP_ADDR_W-1:0] ptr_q, ptr_d;
  draw_req_t             req_q, req_d;
  logic                  draw_q, draw_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  logic last_col_c;
  logic last_row_c;

  assign last_col_c = (col_q == LAST_COL);
  assign last_row_c = (row_q == LAST_ROW);

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ptr_d   = ptr_q;
    req_d   = req_q;

    unique case (state_q)
      ST_IDLE: begin
        col_d = '0;
        row_d = '0;
        ptr_d = '0;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_LATCH;
      ST_LATCH: begin
        req_d.tile_address = TILE_BASE + (TILE_ADDR_W'(map_data) << TILE_SHIFT);
        req_d.x            = COORD_W'(col_q) << COORD_SHIFT;
        req_d.y            = COORD_W'(row_q) << COORD_SHIFT;
        if (SKIP_EN && (map_data == SKIP_INDEX)) state_d = ST_ADVANCE;
        else                                     state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (drawer_done) state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        ptr_d = ptr_q + MAP_ADDR_W'(1);
        if (last_col_c) begin
          col_d = '0;
          row_d = row_q + CNT_W'(1);
        end else begin
          col_d = col_q + CNT_W'(1);
        end
        if (last_col_c && last_row_c) state_d = ST_FINISH;
        else                          state_d = ST_FETCH;
      end
      ST_FINISH: begin
        col_d   = '0;
        row_d   = '0;
        ptr_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Output flags are registered copies of the state being entered
    draw_d       = (state_d == ST_ISSUE);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_FINISH);
  end

  // State, counters, pointer and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      ptr_q        <= '0;
      req_q        <= '0;
      draw_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      ptr_q        <= ptr_d;
      req_q        <= req_d;
      draw_q       <= draw_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign map_address  = ptr_q;
  assign tile_address = req_q.tile_address;
  assign x_out        = req_q.x;
  assign y_out        = req_q.y;
  assign draw         = draw_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule
